vm_text_writer: RTL and testbench

Upstream text-console writer for the video memory `VM` write port (`clka`/`wea`/`addra`/`dina`). It accepts one byte at a time over a valid/ready handshake and tracks a cursor. Printable codes are written into the character grid, and control codes move the cursor or clear cells with 0x20. The display side reads the same grid through `addrb = {row, col}`.

---
 rtl/vm_text_writer.sv | 146 ++++++++++++++
 tb/tb_vm_text_writer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_text_writer.sv
// Text-console writer for the video-memory write port: byte handshake in, cursor-tracked grid writes out.
// Optional `VM_WRITER_CLR_ON_RESET_EN`: blank the whole grid after reset before accepting bytes.
module vm_text_writer #(
    parameter int unsigned COLS  = 32,
    parameter int unsigned ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        vm_we,
    output logic [11:0] vm_addr,
    output logic [7:0]  vm_din,
    output logic [4:0]  cursor_row,
    output logic [4:0]  cursor_col
);

    localparam logic [4:0] COL_LAST = 5'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {IDLE, EXEC, CLR_ROW, CLR_ALL} state_t;

`ifdef VM_WRITER_CLR_ON_RESET_EN
    localparam state_t RESET_STATE = CLR_ALL;
    localparam logic   RESET_READY = 1'b0;
`else
    localparam state_t RESET_STATE = IDLE;
    localparam logic   RESET_READY = 1'b1;
`endif

    state_t     state;
    logic [7:0] char_q;
    logic [4:0] row;
    logic [4:0] col;
    logic [4:0] clr_row;
    logic [4:0] clr_col;
    logic       clr_last;
    logic       printable_c;
    logic       newline_c;

    assign printable_c = (char_q >= 8'h20) && (char_q <= 8'h7E);
    assign newline_c   = (printable_c && (col == COL_LAST)) || (char_q == CH_LF);

    // Internal cursor moves in EXEC; the visible cursor follows one cycle later.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state      <= RESET_STATE;
            char_ready <= RESET_READY;
            vm_we      <= 1'b0;
            vm_addr    <= '0;
            vm_din     <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            char_q     <= '0;
            row        <= '0;
            col        <= '0;
            clr_row    <= '0;
            clr_col    <= '0;
            clr_last   <= 1'b0;
        end else begin
            vm_we      <= 1'b0;
            cursor_row <= row;
            cursor_col <= col;
            case (state)
                IDLE: begin
                    if (char_valid && char_ready) begin
                        char_q     <= char_in;
                        char_ready <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    state      <= IDLE;
                    char_ready <= 1'b1;
                    if (printable_c) begin
                        vm_we   <= 1'b1;
                        vm_addr <= {2'b00, row, col};
                        vm_din  <= char_q;
                        col     <= (col == COL_LAST) ? 5'd0 : col + 5'd1;
                    end else if ((char_q == CH_CR) || (char_q == CH_LF)) begin
                        col <= '0;
                    end else if ((char_q == CH_BS) && (col != 5'd0)) begin
                        col     <= col - 5'd1;
                        vm_we   <= 1'b1;
                        vm_addr <= {2'b00, row, col - 5'd1};
                        vm_din  <= BLANK;
                    end else if (char_q == CH_FF) begin
                        state      <= CLR_ALL;
                        char_ready <= 1'b0;
                        clr_row    <= '0;
                        clr_col    <= '0;
                        clr_last   <= 1'b0;
                    end
                    // Running off the bottom wraps to row 0, which must be blanked first.
                    if (newline_c) begin
                        if (row == ROW_LAST) begin
                            row        <= '0;
                            state      <= CLR_ROW;
                            char_ready <= 1'b0;
                            clr_row    <= '0;
                            clr_col    <= '0;
                            clr_last   <= 1'b0;
                        end else begin
                            row <= row + 5'd1;
                        end
                    end
                end
                CLR_ROW, CLR_ALL: begin
                    if (clr_last) begin
                        state      <= IDLE;
                        char_ready <= 1'b1;
                        if (state == CLR_ALL) begin
                            row <= '0;
                            col <= '0;
                        end
                    end else begin
                        vm_we   <= 1'b1;
                        vm_addr <= {2'b00, clr_row, clr_col};
                        vm_din  <= BLANK;
                        if (clr_col == COL_LAST) begin
                            clr_col <= '0;
                            if ((state == CLR_ROW) || (clr_row == ROW_LAST)) begin
                                clr_last <= 1'b1;
                            end else begin
                                clr_row <= clr_row + 5'd1;
                            end
                        end else begin
                            clr_col <= clr_col + 5'd1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    char_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_text_writer.sv
// Self-checking bench for vm_text_writer: directed scenarios plus random bytes against a grid/cursor model.
module tb_vm_text_writer;

    localparam int         COLS  = 32;
    localparam int         ROWS  = 30;
    localparam logic [7:0] BLANK = 8'h20;

    logic        clk_50mhz = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        vm_we;
    logic [11:0] vm_addr;
    logic [7:0]  vm_din;
    logic [4:0]  cursor_row;
    logic [4:0]  cursor_col;

    vm_text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .vm_we     (vm_we),
        .vm_addr   (vm_addr),
        .vm_din    (vm_din),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    logic [11:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int unsigned wr_cyc[$];
    logic [7:0]  dut_mem[1024];

    logic [11:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    logic [7:0]  model_mem[1024];
    bit          model_written[1024];
    int          mr = 0;
    int          mc = 0;

    always @(posedge clk_50mhz) begin
        cyc <= cyc + 1;
        if (vm_we) begin
            wr_addr.push_back(vm_addr);
            wr_data.push_back(vm_din);
            wr_cyc.push_back(cyc);
            dut_mem[vm_addr[9:0]] <= vm_din;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: grid of COLS x ROWS cells addressed as row*32+col.
    function automatic void model_write(input int r, input int c, input logic [7:0] d);
        exp_addr.push_back(12'(r * 32 + c));
        exp_data.push_back(d);
        model_mem[r * 32 + c]     = d;
        model_written[r * 32 + c] = 1'b1;
    endfunction

    function automatic void model_newline();
        mr = mr + 1;
        if (mr == ROWS) begin
            mr = 0;
            for (int c = 0; c < COLS; c++) model_write(0, c, BLANK);
        end
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            model_write(mr, mc, b);
            mc = mc + 1;
            if (mc == COLS) begin
                mc = 0;
                model_newline();
            end
        end else if (b == 8'h0A) begin
            mc = 0;
            model_newline();
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h08) begin
            if (mc > 0) begin
                mc = mc - 1;
                model_write(mr, mc, BLANK);
            end
        end else if (b == 8'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) model_write(r, c, BLANK);
            mr = 0;
            mc = 0;
        end
    endfunction

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n = 0;
        @(negedge clk_50mhz);
        char_in    = b;
        char_valid = 1'b1;
        while (!char_ready && n < 3000) begin
            @(negedge clk_50mhz);
            n++;
        end
        ok = (n < 3000);
        @(negedge clk_50mhz);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (!char_ready && n < 3000) begin
            @(negedge clk_50mhz);
            n++;
        end
        ok = (n < 3000);
        @(negedge clk_50mhz);
    endtask

    task automatic put(input logic [7:0] b, output bit ok);
        bit a, c;
        model_apply(b);
        send_byte(b, a);
        wait_idle(c);
        ok = a && c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_50mhz);
        #1;
        checks++; if (vm_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", vm_we); end
        checks++; if (vm_addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", vm_addr); end
        checks++; if (vm_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h want 00", vm_din); end
        checks++; if ({cursor_row, cursor_col} !== 10'd0) begin errors++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
`ifdef VM_WRITER_CLR_ON_RESET_EN
        checks++; if (char_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", char_ready); end
`else
        checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", char_ready); end
`endif
        @(negedge clk_50mhz);
        rst = 1'b0;
        mr = 0;
        mc = 0;
    endtask

`ifdef VM_WRITER_CLR_ON_RESET_EN
    task automatic test_clr_on_reset();
        bit ok;
        int bad = 0;
        clear_logs();
        model_apply(8'h0C);
        put(8'h55, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clr_on_reset_timeout: got timeout want accept"); end
        if (wr_addr.size() != exp_addr.size()) bad = 1;
        else foreach (exp_addr[i]) if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clr_on_reset_writes: got %0d writes (%0d bad) want %0d", wr_addr.size(), bad, exp_addr.size()); end
    endtask
`endif

    task automatic test_single_print();
        logic [11:0] a;
        a = 12'(mr * 32 + mc);
        clear_logs();
        model_apply(8'h41);
        @(negedge clk_50mhz);
        char_in    = 8'h41;
        char_valid = 1'b1;
        checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL print_ready_before: got %b want 1", char_ready); end
        @(posedge clk_50mhz); #1;
        checks++; if (char_ready !== 1'b0 || vm_we !== 1'b0) begin errors++; $display("FAIL print_accept: got ready=%b we=%b want 0 0", char_ready, vm_we); end
        @(negedge clk_50mhz);
        char_valid = 1'b0;
        @(posedge clk_50mhz); #1;
        checks++; if (vm_we !== 1'b1 || vm_addr !== a || vm_din !== 8'h41) begin errors++; $display("FAIL print_write: got we=%b addr=%h din=%h want 1 %h 41", vm_we, vm_addr, vm_din, a); end
        checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL print_ready_back: got %b want 1", char_ready); end
        @(posedge clk_50mhz); #1;
        checks++; if (vm_we !== 1'b0) begin errors++; $display("FAIL print_we_pulse: got %b want 0", vm_we); end
        checks++; if (cursor_row !== 5'(mr) || cursor_col !== 5'(mc)) begin errors++; $display("FAIL print_cursor: got (%0d,%0d) want (%0d,%0d)", cursor_row, cursor_col, mr, mc); end
        @(negedge clk_50mhz);
        checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL print_count: got %0d writes want 1", wr_addr.size()); end
    endtask

    task automatic test_col_wrap();
        bit ok, all_ok;
        all_ok = 1'b1;
        put(8'h0D, ok); all_ok &= ok;
        while (mr != 3) begin put(8'h0A, ok); all_ok &= ok; end
        for (int i = 0; i < 31; i++) begin put(8'(8'h61 + (i % 26)), ok); all_ok &= ok; end
        checks++; if (!all_ok || cursor_row !== 5'd3 || cursor_col !== 5'd31) begin errors++; $display("FAIL colwrap_setup: got (%0d,%0d) ok=%b want (3,31)", cursor_row, cursor_col, all_ok); end
        clear_logs();
        put(8'h42, ok);
        checks++; if (!ok || wr_addr.size() != 1 || wr_addr[0] !== 12'h07F || wr_data[0] !== 8'h42) begin errors++; $display("FAIL colwrap_write: got %0d writes, first %h=%h want 07F=42", wr_addr.size(), wr_addr.size() ? wr_addr[0] : 12'h0, wr_data.size() ? wr_data[0] : 8'h0); end
        checks++; if (cursor_row !== 5'd4 || cursor_col !== 5'd0) begin errors++; $display("FAIL colwrap_cursor: got (%0d,%0d) want (4,0)", cursor_row, cursor_col); end
    endtask

    task automatic test_lf_wrap();
        bit ok, all_ok;
        int n = 0;
        int bad = 0;
        int ready_during = 0;
        all_ok = 1'b1;
        put(8'h0D, ok); all_ok &= ok;
        while (mr != 29) begin put(8'h0A, ok); all_ok &= ok; end
        for (int i = 0; i < 5; i++) begin put(8'h30 + 8'(i), ok); all_ok &= ok; end
        checks++; if (!all_ok || cursor_row !== 5'd29 || cursor_col !== 5'd5) begin errors++; $display("FAIL lfwrap_setup: got (%0d,%0d) want (29,5)", cursor_row, cursor_col); end
        clear_logs();
        model_apply(8'h0A);
        send_byte(8'h0A, ok);
        while (!char_ready && n < 200) begin
            @(posedge clk_50mhz); #1;
            if (vm_we && char_ready) ready_during++;
            n++;
        end
        repeat (2) @(negedge clk_50mhz);
        checks++; if (!ok || n >= 200 || ready_during != 0) begin errors++; $display("FAIL lfwrap_ready: got ready high on %0d write cycles (timeout=%0d) want 0", ready_during, n >= 200); end
        for (int i = 0; i < 32 && i < wr_addr.size(); i++)
            if (wr_addr[i] !== 12'(i) || wr_data[i] !== BLANK) bad++;
        checks++; if (wr_addr.size() != 32 || bad != 0) begin errors++; $display("FAIL lfwrap_writes: got %0d writes (%0d bad) want 32 blanks at 000..01F", wr_addr.size(), bad); end
        checks++; if (wr_cyc.size() == 32 && wr_cyc[31] - wr_cyc[0] != 31) begin errors++; $display("FAIL lfwrap_consecutive: got span %0d want 31", wr_cyc[31] - wr_cyc[0]); end
        checks++; if (cursor_row !== 5'd0 || cursor_col !== 5'd0 || char_ready !== 1'b1) begin errors++; $display("FAIL lfwrap_cursor: got (%0d,%0d) ready=%b want (0,0) 1", cursor_row, cursor_col, char_ready); end
    endtask

    task automatic test_backspace();
        bit ok, all_ok;
        all_ok = 1'b1;
        while (mr != 2) begin put(8'h0A, ok); all_ok &= ok; end
        clear_logs();
        put(8'h08, ok); all_ok &= ok;
        checks++; if (!all_ok || wr_addr.size() != 0 || cursor_row !== 5'd2 || cursor_col !== 5'd0) begin errors++; $display("FAIL bs_col0: got %0d writes cursor (%0d,%0d) want 0 (2,0)", wr_addr.size(), cursor_row, cursor_col); end
        clear_logs();
        put(8'h43, ok); all_ok &= ok;
        put(8'h08, ok); all_ok &= ok;
        checks++; if (!all_ok || wr_addr.size() != 2 || wr_addr[1] !== 12'h040 || wr_data[1] !== BLANK || wr_data[0] !== 8'h43) begin errors++; $display("FAIL bs_erase: got %0d writes, last %h=%h want 040=20", wr_addr.size(), wr_addr.size() ? wr_addr[wr_addr.size()-1] : 12'h0, wr_data.size() ? wr_data[wr_data.size()-1] : 8'h0); end
        checks++; if (cursor_row !== 5'd2 || cursor_col !== 5'd0) begin errors++; $display("FAIL bs_cursor: got (%0d,%0d) want (2,0)", cursor_row, cursor_col); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        int bad = 0;
        int unsigned acc[6];
        logic [7:0] msg[6];
        msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21};
        put(8'h0D, ok);
        clear_logs();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            model_apply(msg[i]);
            @(negedge clk_50mhz);
            char_in    = msg[i];
            char_valid = 1'b1;
            while (!char_ready && n < 100) begin @(negedge clk_50mhz); n++; end
            @(posedge clk_50mhz); #1;
            acc[i] = cyc;
        end
        @(negedge clk_50mhz);
        char_valid = 1'b0;
        wait_idle(ok);
        for (int i = 1; i < 6; i++) if (acc[i] - acc[i-1] != 2) bad++;
        checks++; if (!ok || n >= 100 || bad != 0) begin errors++; $display("FAIL b2b_rate: got %0d gaps not equal 2 want 0", bad); end
        bad = 0;
        if (wr_addr.size() != exp_addr.size()) bad = 1;
        else foreach (exp_addr[i]) if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_writes: got %0d writes (%0d bad) want %0d", wr_addr.size(), bad, exp_addr.size()); end
    endtask

    task automatic test_form_feed();
        bit ok;
        int bad = 0;
        clear_logs();
        put(8'h0C, ok);
        if (wr_addr.size() != exp_addr.size()) bad = 1;
        else foreach (exp_addr[i]) if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) bad++;
        checks++; if (!ok || wr_addr.size() != 960 || bad != 0) begin errors++; $display("FAIL ff_writes: got %0d writes (%0d bad) want 960 blanks", wr_addr.size(), bad); end
        checks++; if (wr_addr.size() == 960 && (wr_addr[959] !== 12'h3BF || wr_cyc[959] - wr_cyc[0] != 959)) begin errors++; $display("FAIL ff_span: got last %h span %0d want 3BF 959", wr_addr[959], wr_cyc[959] - wr_cyc[0]); end
        checks++; if (cursor_row !== 5'd0 || cursor_col !== 5'd0 || char_ready !== 1'b1) begin errors++; $display("FAIL ff_cursor: got (%0d,%0d) ready=%b want (0,0) 1", cursor_row, cursor_col, char_ready); end
    endtask

    task automatic test_random();
        bit ok;
        int bad;
        int sel;
        logic [7:0] b;
        logic [7:0] others[5];
        others = '{8'h00, 8'h7F, 8'h1B, 8'hFF, 8'h09};
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      b = 8'($urandom_range(32, 126));
            else if (sel < 80) b = 8'h0A;
            else if (sel < 85) b = 8'h0D;
            else if (sel < 93) b = 8'h08;
            else if (sel < 98) b = others[$urandom_range(0, 4)];
            else               b = 8'h0C;
            clear_logs();
            put(b, ok);
            bad = 0;
            if (wr_addr.size() != exp_addr.size()) bad = 1;
            else foreach (exp_addr[i]) if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) bad++;
            checks++; if (!ok || bad != 0) begin errors++; $display("FAIL rand_writes byte=%h: got %0d writes (%0d bad) want %0d", b, wr_addr.size(), bad, exp_addr.size()); end
            checks++; if (cursor_row !== 5'(mr) || cursor_col !== 5'(mc)) begin errors++; $display("FAIL rand_cursor byte=%h: got (%0d,%0d) want (%0d,%0d)", b, cursor_row, cursor_col, mr, mc); end
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (model_written[i] && dut_mem[i] !== model_mem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_grid: got %0d differing cells want 0", bad); end
    endtask

    task automatic test_reset_midsweep();
        bit ok;
        int n = 0;
        int w = 0;
        send_byte(8'h0C, ok);
        while (w < 100 && n < 2000) begin
            @(posedge clk_50mhz); #1;
            if (vm_we) w++;
            n++;
        end
        checks++; if (!ok || w != 100) begin errors++; $display("FAIL midsweep_reach: got %0d writes want 100", w); end
        rst = 1'b1;
        @(posedge clk_50mhz); #1;
        checks++; if (vm_we !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 5'd0) begin errors++; $display("FAIL midsweep_reset: got we=%b cursor (%0d,%0d) want 0 (0,0)", vm_we, cursor_row, cursor_col); end
        @(negedge clk_50mhz);
        rst = 1'b0;
        mr = 0;
        mc = 0;
        wr_addr.delete();
        repeat (1100) @(posedge clk_50mhz);
        #1;
`ifdef VM_WRITER_CLR_ON_RESET_EN
        checks++; if (wr_addr.size() != 960 || char_ready !== 1'b1) begin errors++; $display("FAIL midsweep_after: got %0d writes ready=%b want 960 1", wr_addr.size(), char_ready); end
`else
        checks++; if (wr_addr.size() != 0 || char_ready !== 1'b1) begin errors++; $display("FAIL midsweep_after: got %0d writes ready=%b want 0 1", wr_addr.size(), char_ready); end
`endif
    endtask

    initial begin
        test_reset();
`ifdef VM_WRITER_CLR_ON_RESET_EN
        test_clr_on_reset();
`endif
        test_single_print();
        test_col_wrap();
        test_lf_wrap();
        test_backspace();
        test_back_to_back();
        test_form_feed();
        test_random();
        test_reset_midsweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
